// File: rtl/relu_maxpool2x2_if.sv
// Streaming bus between the convolution stage and the ReLU + 2x2 max-pool stage.
// The producer holds the master modport and the pooling block holds the slave.
interface relu_maxpool2x2_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic [DATA_W-1:0] pool_out;
    logic              valid_out;
    logic              frame_done;

    modport master (
        output data_in,
        output valid_in,
        input  pool_out,
        input  valid_out,
        input  frame_done
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output pool_out,
        output valid_out,
        output frame_done
    );
endinterface

// File: rtl/relu_maxpool2x2.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-order sample stream.
// Even rows fold pair maxima into a half-width row buffer; odd rows complete the windows.
module relu_maxpool2x2 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned MAP_W  = 26,
    parameter int unsigned MAP_H  = 26
) (
    input logic                clk,
    input logic                rst,
    relu_maxpool2x2_if.slave   bus
);
    localparam int unsigned OutW = MAP_W / 2;
    localparam int unsigned OutH = MAP_H / 2;
    localparam int unsigned CW   = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int unsigned RW   = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int unsigned KW   = (OutW > 1) ? $clog2(OutW) : 1;
    localparam bit          ColOdd = (MAP_W % 2) == 1;
    localparam bit          RowOdd = (MAP_H % 2) == 1;

    localparam logic [CW-1:0] ColLast     = CW'(MAP_W - 1);
    localparam logic [CW-1:0] ColPairLast = CW'(2 * OutW - 1);
    localparam logic [RW-1:0] RowLast     = RW'(MAP_H - 1);
    localparam logic [RW-1:0] RowPairLast = RW'(2 * OutH - 1);

    function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] pool_q, pool_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] row_buf_q [OutW];

    logic [DATA_W-1:0] relu;
    logic [DATA_W-1:0] pair_max;
    logic [KW-1:0]     k;
    logic              col_paired, row_paired;
    logic              buf_we;

    always_comb begin
        relu       = bus.data_in[DATA_W-1] ? '0 : bus.data_in;
        pair_max   = umax(hold_q, relu);
        k          = KW'(col_q >> 1);
        // Only the trailing column/row of an odd-sized map is left unpaired.
        col_paired = !(ColOdd && (col_q == ColLast));
        row_paired = !(RowOdd && (row_q == RowLast));

        col_d   = col_q;
        row_d   = row_q;
        hold_d  = hold_q;
        pool_d  = pool_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        buf_we  = 1'b0;

        if (bus.valid_in) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (col_paired && row_paired) begin
                if (!col_q[0]) begin
                    hold_d = relu;
                end else if (!row_q[0]) begin
                    buf_we = 1'b1;
                end else begin
                    pool_d  = umax(pair_max, row_buf_q[k]);
                    valid_d = 1'b1;
                    done_d  = (col_q == ColPairLast) && (row_q == RowPairLast);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            pool_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            hold_q  <= hold_d;
            pool_q  <= pool_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Buffer entries are always rewritten on the even row before the odd row reads them.
    always_ff @(posedge clk) begin
        if (buf_we && !rst) begin
            row_buf_q[k] <= pair_max;
        end
    end

    assign bus.pool_out   = pool_q;
    assign bus.valid_out  = valid_q;
    assign bus.frame_done = done_q;

endmodule

// File: doc/relu_maxpool2x2.md
Name: relu_maxpool2x2

Overview:
- Streaming stage directly downstream of the convolution layer; consumes the 16-bit signed convolution stream one sample per accepted beat, in raster order.
- Applies ReLU, then 2x2 max pooling with stride 2. Emits one pooled sample per 2x2 window, in raster order of the pooled map.
- Holds one half-width row buffer of partial maxima. No backpressure: input is accepted whenever valid_in is high.

Parameters:
- DATA_W, 16, sample width; two's-complement signed.
- MAP_W, 26, input feature-map width in samples; must be >= 2.
- MAP_H, 26, input feature-map height in rows; must be >= 2.
- Derived: OUT_W = floor(MAP_W/2), OUT_H = floor(MAP_H/2), row buffer depth = OUT_W.

Ports:
- clk, input, 1, sole clock; all state changes on rising edge.
- rst, input, 1, synchronous, active-high reset.
- data_in, input, DATA_W, convolution sample; signed.
- valid_in, input, 1, data_in is valid this cycle; gaps are allowed.
- pool_out, output, DATA_W, pooled sample; always >= 0.
- valid_out, output, 1, single-cycle qualifier for pool_out.
- frame_done, output, 1, pulses together with valid_out for pooled pixel (OUT_H-1, OUT_W-1).

Behaviour:
- Reset (rst high at an edge):
  - col, row counters and pool_out go to 0; valid_out and frame_done go to 0.
  - Row buffer contents are don't-care; every entry is rewritten before it is read.
- ReLU: r = (data_in[DATA_W-1] == 1) ? 0 : data_in. Comparisons are then unsigned on non-negative values.
- Counters:
  - Advance only on accepted beats (valid_in == 1).
  - col runs 0..MAP_W-1 and then wraps to 0, which increments row.
  - row runs 0..MAP_H-1 and then wraps to 0, starting a new frame with no idle cycle required.
- Let k = col >> 1. A column is "paired" when col < 2*OUT_W; a row is "paired" when row < 2*OUT_H.
- Even row (row[0] == 0), paired column:
  - Even col: hold_reg <= r.
  - Odd col: buf[k] <= max(hold_reg, r).
- Odd row, paired row and paired column:
  - Even col: hold_reg <= r.
  - Odd col: pool_out <= max(hold_reg, r, buf[k]); valid_out <= 1 on the next edge.
- Unpaired samples (last column when MAP_W is odd, last row when MAP_H is odd) are consumed and discarded; counters still advance.
- Latency: pool_out and valid_out are registered 1 cycle after the accepted beat that completes a window (odd row, odd col).
- valid_out is high for exactly one cycle per window; otherwise it is 0. pool_out holds its last value while valid_out is low.
- frame_done is high only in the cycle valid_out carries window (OUT_H-1, OUT_W-1).
- Outputs per frame: exactly OUT_W*OUT_H valid_out pulses, independent of gaps in valid_in.
- Simultaneous rst and valid_in: reset wins and the beat is discarded.
- Reset mid-frame: the partial frame is abandoned, and the next accepted beat is treated as pixel (0,0).
- Ties: equal maxima give the same value, so no ordering rule is needed.
- Width: max is taken over DATA_W-bit values with no growth; the output equals one of the inputs (or 0).

Test Plan:
- MAP_W=MAP_H=4, input values 1..16 raster, valid_in continuous -> 4 outputs 6, 8, 14, 16.
  - Each valid_out appears 1 cycle after inputs 6, 8, 14, 16 respectively.
  - frame_done accompanies 16.
- MAP_W=MAP_H=4, all samples negative (-5, 0x FFFB) except row 1 col 1 = -1 -> outputs 0,0,0,0 (ReLU clamps); valid_out count = 4.
- MAP_W=5, MAP_H=5, values 1..25:
  - outputs 7, 9, 17, 19.
  - col 4 and row 4 are ignored; frame_done on 19.
  - A second frame then follows with no idle cycle and produces the same results.
- Same stimulus as the first scenario with random 0-3 cycle gaps in valid_in -> identical output values and order; each valid_out is exactly 1 cycle after its completing beat.
- Assert rst for 1 cycle after input 7 of a 4x4 frame, then send a clean 1..16 frame:
  - valid_out stays low during and immediately after reset.
  - Outputs are then 6, 8, 14, 16; no stale output from the aborted frame.
- Window values {0x7FFF, 0x8000, 0x0001, 0x7FFE} -> output 0x7FFF (0x8000 is negative and clamps to 0; it is not treated as a large unsigned value).
